// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage / writeback port and the ID/EX staging register.
// master = upstream decode side, slave = the id_ex_stage itself.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic          id_alu_src;
  logic          id_reg_dst;
  logic          id_uses_rt;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [15:0]   id_imm;
  logic          wb_reg_write;
  logic [RW-1:0] wb_write_reg;
  logic [DW-1:0] wb_data;
  logic          id_hold;
  logic [DW-1:0] ex_A;
  logic [DW-1:0] ex_B;
  logic [2:0]    ex_alu_ctrl;
  logic [DW-1:0] ex_rt_data;
  logic [RW-1:0] ex_write_reg;
  logic          ex_valid;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;
  logic          ex_illegal;

  modport master (
    output id_valid, id_alu_op, id_funct, id_alu_src, id_reg_dst, id_uses_rt,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           wb_reg_write, wb_write_reg, wb_data,
    input  id_hold, ex_A, ex_B, ex_alu_ctrl, ex_rt_data, ex_write_reg,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
  );

  modport slave (
    input  id_valid, id_alu_op, id_funct, id_alu_src, id_reg_dst, id_uses_rt,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           wb_reg_write, wb_write_reg, wb_data,
    output id_hold, ex_A, ex_B, ex_alu_ctrl, ex_rt_data, ex_write_reg,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: ALU control decode, operand staging, load-use bubble insertion.
// Optional macro ID_EX_WB_BYPASS_EN enables same-cycle writeback-to-operand bypass.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic         clk,
  input logic         rst_n,
  input logic         stall,
  input logic         flush,
  id_ex_stage_if.slave bus
);

  // {illegal, alu_ctrl[2:0]}
  function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] r;
    case (op)
      2'b00:   r = 4'b0_010;
      2'b01:   r = 4'b0_110;
      2'b11:   r = 4'b0_001;
      default: begin
        case (funct)
          6'b100000: r = 4'b0_010;
          6'b100010: r = 4'b0_110;
          6'b100100: r = 4'b0_000;
          6'b100101: r = 4'b0_001;
          6'b101010: r = 4'b0_111;
          default:   r = 4'b1_010;
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic logic signed [DW-1:0] imm_extend(input logic [15:0] imm, input logic zext);
    logic signed [DW-1:0] r;
    r = {{(DW-16){zext ? 1'b0 : imm[15]}}, imm};
    return r;
  endfunction

`ifdef ID_EX_WB_BYPASS_EN
  function automatic logic signed [DW-1:0] wb_bypass(input logic [RW-1:0] idx,
                                                      input logic [DW-1:0] rf_data);
    logic hit;
    hit = bus.wb_reg_write && (bus.wb_write_reg != '0) && (bus.wb_write_reg == idx);
    return hit ? bus.wb_data : rf_data;
  endfunction
`endif

  logic signed [DW-1:0] rs_opnd_p0;
  logic signed [DW-1:0] rt_opnd_p0;
  logic signed [DW-1:0] imm_p0;
  logic [3:0]           dec_p0;
  logic                 haz_p0;

  logic                 vld_p1;
  logic                 reg_write_p1;
  logic                 mem_read_p1;
  logic                 mem_write_p1;
  logic                 mem_to_reg_p1;
  logic                 illegal_p1;
  logic [2:0]           alu_ctrl_p1;
  logic [RW-1:0]        write_reg_p1;
  logic signed [DW-1:0] a_p1;
  logic signed [DW-1:0] b_p1;
  logic signed [DW-1:0] rt_data_p1;

  // ---- p0: decode and operand selection from ID ----
`ifdef ID_EX_WB_BYPASS_EN
  assign rs_opnd_p0 = wb_bypass(bus.id_rs, bus.id_rs_data);
  assign rt_opnd_p0 = wb_bypass(bus.id_rt, bus.id_rt_data);
`else
  logic unused_wb;
  assign unused_wb  = ^{bus.wb_reg_write, bus.wb_write_reg, bus.wb_data};
  assign rs_opnd_p0 = bus.id_rs_data;
  assign rt_opnd_p0 = bus.id_rt_data;
`endif

  always_comb begin
    dec_p0 = alu_decode(bus.id_alu_op, bus.id_funct);
    imm_p0 = imm_extend(bus.id_imm, bus.id_alu_op == 2'b11);
  end

  // Load-use: the load now in EX produces its data too late for the instruction in ID.
  assign haz_p0 = vld_p1 & mem_read_p1 & (write_reg_p1 != '0) &
                  ((write_reg_p1 == bus.id_rs) | (bus.id_uses_rt & (write_reg_p1 == bus.id_rt)));
  assign bus.id_hold = haz_p0 & bus.id_valid;

  // ---- p1: ID/EX register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      illegal_p1    <= 1'b0;
      alu_ctrl_p1   <= 3'b000;
      write_reg_p1  <= '0;
      a_p1          <= '0;
      b_p1          <= '0;
      rt_data_p1    <= '0;
    end else if (!stall) begin
      if (flush || bus.id_hold) begin
        vld_p1        <= 1'b0;
        reg_write_p1  <= 1'b0;
        mem_read_p1   <= 1'b0;
        mem_write_p1  <= 1'b0;
        mem_to_reg_p1 <= 1'b0;
        illegal_p1    <= 1'b0;
        alu_ctrl_p1   <= 3'b010;
        write_reg_p1  <= '0;
        a_p1          <= '0;
        b_p1          <= '0;
        rt_data_p1    <= '0;
      end else begin
        // An empty ID slot still moves data through but never carries side effects.
        vld_p1        <= bus.id_valid;
        reg_write_p1  <= bus.id_valid & bus.id_reg_write & ~dec_p0[3];
        mem_read_p1   <= bus.id_valid & bus.id_mem_read;
        mem_write_p1  <= bus.id_valid & bus.id_mem_write;
        mem_to_reg_p1 <= bus.id_valid & bus.id_mem_to_reg;
        illegal_p1    <= bus.id_valid & dec_p0[3];
        alu_ctrl_p1   <= dec_p0[2:0];
        write_reg_p1  <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        a_p1          <= rs_opnd_p0;
        b_p1          <= bus.id_alu_src ? imm_p0 : rt_opnd_p0;
        rt_data_p1    <= rt_opnd_p0;
      end
    end
  end

  assign bus.ex_valid      = vld_p1;
  assign bus.ex_reg_write  = reg_write_p1;
  assign bus.ex_mem_read   = mem_read_p1;
  assign bus.ex_mem_write  = mem_write_p1;
  assign bus.ex_mem_to_reg = mem_to_reg_p1;
  assign bus.ex_illegal    = illegal_p1;
  assign bus.ex_alu_ctrl   = alu_ctrl_p1;
  assign bus.ex_write_reg  = write_reg_p1;
  assign bus.ex_A          = a_p1;
  assign bus.ex_B          = b_p1;
  assign bus.ex_rt_data    = rt_data_p1;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Pipeline register and operand-staging stage directly upstream of the ALU execute block. Captures decoded instruction fields from ID and registers A, B and the 3-bit ALU control word the ALU consumes. Also registers the control bits needed by MEM/WB, detects load-use hazards, and inserts bubbles. Supports external stall and flush from the hazard/branch logic.

Parameters:
- DW, 32, datapath width of A, B, rt store data.
- RW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all stage registers (downstream busy)
- flush  in  1  squash the instruction entering EX (branch taken)
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  2  main-decoder ALU op class
- id_funct  in  6  R-type funct field
- id_alu_src  in  1  1: B = extended immediate, 0: B = rt data
- id_reg_dst  in  1  1: dest = rd, 0: dest = rt
- id_uses_rt  in  1  instruction reads rt as a source
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
- id_rs, id_rt, id_rd  in  RW each  register indices
- id_rs_data, id_rt_data  in  DW each  register-file read data
- id_imm  in  16  immediate field
- wb_reg_write  in  1  WB stage writes the register file this cycle
- wb_write_reg  in  RW  WB destination index
- wb_data  in  DW  WB write data
- id_hold  out  1  combinational; ID/IF must hold (load-use)
- ex_A, ex_B  out  DW  ALU operands
- ex_alu_ctrl  out  3  ALU control word
- ex_rt_data  out  DW  store data
- ex_write_reg  out  RW  destination index
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal  out  1 each

Behaviour:
- Reset (async, rst_n=0): every registered output is 0. id_hold=0 while in reset.
- Hazard: haz = ex_valid & ex_mem_read & (ex_write_reg!=0) & ((ex_write_reg==id_rs) | (id_uses_rt & ex_write_reg==id_rt)). id_hold = haz & id_valid.
- Per rising edge, priority order:
  - 1. stall=1: hold every register.
  - 2. flush=1: bubble.
  - 3. id_hold=1: bubble.
  - 4. Otherwise load from ID with ex_valid=id_valid.
- Bubble: ex_valid and all control outputs (reg_write, mem_*, ex_illegal) = 0. Data outputs = 0, ex_alu_ctrl = 3'b010.
- id_valid=0 and no bubble: loads normally, but all control bits are forced to 0.
- ALU control decode (registered):
  - alu_op 00 → 010 (add)
  - alu_op 01 → 110 (sub)
  - alu_op 11 → 001 (or)
  - alu_op 10 → by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Any other funct with alu_op 10 → 010, ex_illegal=1, ex_reg_write forced 0.
- Immediate extension: sign-extend id_imm to DW. When alu_op=11, zero-extend instead.
- ex_A = rs operand.
- ex_B = id_alu_src ? extended imm : rt operand.
- ex_rt_data = rt operand, regardless of alu_src.
- ex_write_reg = id_reg_dst ? id_rd : id_rt.
- Latency: one cycle from ID inputs to ex_* outputs. No combinational path from ID inputs to ex_* outputs.
- Reset asserted mid-operation clears the stage immediately. No partial state survives.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- When defined: rs operand = wb_data if wb_reg_write & wb_write_reg!=0 & wb_write_reg==id_rs, else id_rs_data. The rt operand uses the same rule against id_rt. This is a write-through bypass for the same-cycle register-file write.
- When undefined: operands come directly from id_rs_data/id_rt_data. wb_* ports remain present but are ignored.

Test Plan:
- Reset: rst_n low → all ex_* =0, id_hold=0.
- R-type decode: alu_op=10, funct=100010, reg_dst=1, rs_data=5, rt_data=3, rd=9 → next cycle ex_alu_ctrl=110, ex_A=5, ex_B=3, ex_write_reg=9, ex_valid=1.
- Immediate paths:
  - alu_src=1, imm=16'hFFFE, alu_op=00 → ex_B=32'hFFFFFFFE, ctrl=010.
  - alu_op=11 → ex_B=32'h0000FFFE, ctrl=001.
- Load-use: lw to r4 in EX, then ID add with rs=4 → id_hold=1; next edge ex_valid=0 with controls 0. Following edge loads the add.
- Stall/flush priority:
  - stall=1 & flush=1 → outputs unchanged.
  - Then stall=0 & flush=1 → ex_valid=0.
- Bypass (macro on): wb_reg_write=1, wb_write_reg=7, wb_data=32'hDEADBEEF, id_rs=7 → ex_A=32'hDEADBEEF.
- Bypass (macro off): same stimulus → ex_A=id_rs_data.
- Bypass to r0: same stimulus with wb_write_reg=0 → ex_A=id_rs_data.
